io_output_reg: RTL and testbench

IO_OUTPUT_REG -- requirements
Module: io_output_reg

---
 rtl/io_output_reg.sv | 94 +++++++++
 tb/tb_io_output_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/io_output_reg.sv
// Memory-mapped output register block: three CPU-writable output ports with
// per-port valid/ack handshakes, sticky overrun flags and a STATUS readback.
module io_output_reg (
   input  logic        io_clk,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        write_io_enable,
   input  logic [2:0]  out_ack,
   output logic [31:0] out_port0,
   output logic [31:0] out_port1,
   output logic [31:0] out_port2,
   output logic [2:0]  out_valid,
   output logic [31:0] io_read_data
);

   localparam logic [5:0] CODE_PORT0  = 6'b100000;
   localparam logic [5:0] CODE_PORT1  = 6'b100001;
   localparam logic [5:0] CODE_PORT2  = 6'b100010;
   localparam logic [5:0] CODE_STATUS = 6'b100011;

   logic [5:0]  code;
   logic [2:0]  port_wr;
   logic        status_wr;
   logic [2:0]  valid_q, valid_d;
   logic [2:0]  overrun_q, overrun_d;
   logic [2:0]  overrun_set;
   logic [2:0]  overrun_clr;
   logic [31:0] port0_q, port1_q, port2_q;
   logic [31:0] status_word;

   assign code      = addr[7:2];
   assign port_wr   = {3{write_io_enable}} & {code == CODE_PORT2,
                                              code == CODE_PORT1,
                                              code == CODE_PORT0};
   assign status_wr = write_io_enable && (code == CODE_STATUS);

   // Handshake: out_valid[n] is a level flag raised by a port write and held
   // until the peripheral pulses out_ack[n] for one cycle; an ack in the same
   // cycle as a new write retires the old data, so the new data stays valid.
   always_comb begin
      valid_d     = valid_q;
      overrun_set = 3'b000;
      overrun_clr = 3'b000;
      for (int n = 0; n < 3; n++) begin
         if (port_wr[n]) begin
            valid_d[n]     = 1'b1;
            overrun_set[n] = valid_q[n] & ~out_ack[n];
         end else if (out_ack[n]) begin
            valid_d[n] = 1'b0;
         end
      end
      if (status_wr)
         overrun_clr = datain[6:4];
      // A new overrun takes priority over a simultaneous W1C of the same bit.
      overrun_d = (overrun_q & ~overrun_clr) | overrun_set;
   end

   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
         port0_q   <= 32'h0;
         port1_q   <= 32'h0;
         port2_q   <= 32'h0;
         valid_q   <= 3'b000;
         overrun_q <= 3'b000;
      end else begin
         if (port_wr[0]) port0_q <= datain;
         if (port_wr[1]) port1_q <= datain;
         if (port_wr[2]) port2_q <= datain;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign status_word = {25'h0, overrun_q, 1'b0, valid_q};

   // Readback shows registered (pre-edge) values and has no side effects.
   always_comb begin
      io_read_data = 32'h0;
      case (code)
         CODE_PORT0:  io_read_data = port0_q;
         CODE_PORT1:  io_read_data = port1_q;
         CODE_PORT2:  io_read_data = port2_q;
         CODE_STATUS: io_read_data = status_word;
         default:     io_read_data = 32'h0;
      endcase
   end

   assign out_port0 = port0_q;
   assign out_port1 = port1_q;
   assign out_port2 = port2_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_io_output_reg.sv
// Directed self-checking bench for io_output_reg: reset, writes, handshake,
// overrun/W1C, collisions, unmapped accesses and mid-operation reset.
module tb_io_output_reg;

   logic        io_clk;
   logic        resetn;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        write_io_enable;
   logic [2:0]  out_ack;
   logic [31:0] out_port0, out_port1, out_port2;
   logic [2:0]  out_valid;
   logic [31:0] io_read_data;

   int checks = 0;
   int errors = 0;

   io_output_reg dut (
      .io_clk          (io_clk),
      .resetn          (resetn),
      .addr            (addr),
      .datain          (datain),
      .write_io_enable (write_io_enable),
      .out_ack         (out_ack),
      .out_port0       (out_port0),
      .out_port1       (out_port1),
      .out_port2       (out_port2),
      .out_valid       (out_valid),
      .io_read_data    (io_read_data)
   );

   // clock / reset
   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change on the falling edge, results sampled 1ns after the rising edge
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ack);
      @(negedge io_clk);
      addr = a; datain = d; write_io_enable = 1'b1; out_ack = ack;
      @(posedge io_clk); #1;
      write_io_enable = 1'b0; out_ack = 3'b000; addr = 32'h0; datain = 32'h0;
   endtask

   task automatic do_ack(input logic [2:0] ack);
      @(negedge io_clk);
      out_ack = ack;
      @(posedge io_clk); #1;
      out_ack = 3'b000;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = io_read_data;
   endtask

   logic [31:0] rd;

   initial begin
      resetn = 1'b1; addr = 32'h0; datain = 32'h0; write_io_enable = 1'b0; out_ack = 3'b000;

      // asynchronous reset before any clock edge
      #2 resetn = 1'b0;
      #1;
      check("rst_port0", out_port0, 32'h0);
      check("rst_port1", out_port1, 32'h0);
      check("rst_port2", out_port2, 32'h0);
      check("rst_valid", {29'h0, out_valid}, 32'h0);
      do_read(32'h8C, rd);
      check("rst_status", rd, 32'h0);

      // writes and acks ignored while reset is held
      @(negedge io_clk);
      addr = 32'h80; datain = 32'hFFFF_FFFF; write_io_enable = 1'b1; out_ack = 3'b111;
      @(posedge io_clk); #1;
      check("rst_hold_port0", out_port0, 32'h0);
      check("rst_hold_valid", {29'h0, out_valid}, 32'h0);

      // first write accepted on the first edge after release
      @(negedge io_clk);
      resetn = 1'b1; addr = 32'h80; datain = 32'h0000_00A5; out_ack = 3'b000;
      @(posedge io_clk); #1;
      write_io_enable = 1'b0;
      check("first_wr_port0", out_port0, 32'h0000_00A5);
      check("first_wr_valid", {29'h0, out_valid}, 32'h1);
      do_ack(3'b001);
      check("ack0_valid", {29'h0, out_valid}, 32'h0);
      do_ack(3'b111);
      check("idle_ack_valid", {29'h0, out_valid}, 32'h0);
      do_read(32'h8C, rd);
      check("idle_ack_status", rd, 32'h0);

      // basic write to port1
      do_write(32'h84, 32'hDEAD_BEEF, 3'b000);
      check("wr1_port1", out_port1, 32'hDEAD_BEEF);
      check("wr1_valid", {29'h0, out_valid}, 32'h2);
      check("wr1_port0_kept", out_port0, 32'h0000_00A5);
      do_read(32'h84, rd);
      check("wr1_readback", rd, 32'hDEAD_BEEF);
      do_ack(3'b010);
      check("ack1_valid", {29'h0, out_valid}, 32'h0);

      // overrun on port0 then W1C
      do_write(32'h80, 32'h11, 3'b000);
      do_write(32'h80, 32'h22, 3'b000);
      check("ovr_port0", out_port0, 32'h22);
      do_read(32'h8C, rd);
      check("ovr_status", rd, 32'h11);
      do_write(32'h8C, 32'hFFFF_FF8F, 3'b000);
      do_read(32'h8C, rd);
      check("status_ro_bits", rd, 32'h11);
      do_write(32'h8C, 32'h10, 3'b000);
      do_read(32'h8C, rd);
      check("w1c_status", rd, 32'h01);

      // read during write to the same address shows the old value
      @(negedge io_clk);
      addr = 32'h80; datain = 32'h33; write_io_enable = 1'b1;
      #1;
      check("rd_pre_edge", io_read_data, 32'h22);
      @(posedge io_clk); #1;
      write_io_enable = 1'b0;
      check("rd_post_edge", io_read_data, 32'h33);
      do_write(32'h8C, 32'h10, 3'b000);

      // write + ack collision on port2
      do_write(32'h88, 32'h44, 3'b000);
      do_write(32'h88, 32'h55, 3'b100);
      check("coll_port2", out_port2, 32'h55);
      do_read(32'h8C, rd);
      check("coll_status", rd, 32'h05);

      // unmapped write/read
      do_write(32'h90, 32'hFFFF_FFFF, 3'b000);
      check("unmap_port0", out_port0, 32'h33);
      check("unmap_port1", out_port1, 32'hDEAD_BEEF);
      check("unmap_port2", out_port2, 32'h55);
      do_read(32'h90, rd);
      check("unmap_read", rd, 32'h0);
      do_read(32'h8C, rd);
      check("unmap_status", rd, 32'h05);

      // overrun persists across a W1C of a different bit
      do_write(32'h80, 32'h66, 3'b000);
      do_write(32'h8C, 32'h20, 3'b000);
      do_read(32'h8C, rd);
      check("ovr_keep_status", rd, 32'h15);

      // build valid=111, overrun=101, then reset mid-operation
      do_write(32'h84, 32'h77, 3'b000);
      do_write(32'h88, 32'h88, 3'b000);
      do_read(32'h8C, rd);
      check("pre_rst_status", rd, 32'h57);
      @(negedge io_clk);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_port0", out_port0, 32'h0);
      check("mid_rst_port2", out_port2, 32'h0);
      check("mid_rst_valid", {29'h0, out_valid}, 32'h0);
      do_read(32'h8C, rd);
      check("mid_rst_status", rd, 32'h0);
      @(negedge io_clk);
      resetn = 1'b1;
      do_write(32'h80, 32'h99, 3'b000);
      check("post_rst_port0", out_port0, 32'h99);
      do_read(32'h8C, rd);
      check("post_rst_status", rd, 32'h01);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
